// File: rtl/t_route_stage_pkg.sv
// ============================================================================
// Module      : t_route_stage_pkg
// Description : Shared direction constants, packet field offsets and small
//               helpers for the BFT t-switch route stage, the arbiter and the
//               t-switch top.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package t_route_stage_pkg;

    // Direction request codes exchanged between route stage and arbiter.
    typedef enum logic [1:0] {
        DIR_VOID  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    // Packet layout: the valid flag is the MSB, the destination address
    // sits immediately below it (A_W bits counting down from this index).
    function automatic int pkt_valid_bit(input int p_w);
        return p_w - 1;
    endfunction

    function automatic int pkt_addr_msb(input int p_w);
        return p_w - 2;
    endfunction

    // Direction code that means "granted" for input port idx (0=L,1=R,2=U).
    function automatic dir_e port_code(input int idx);
        case (idx)
            0:       return DIR_LEFT;
            1:       return DIR_RIGHT;
            default: return DIR_UP;
        endcase
    endfunction

    // Select line of the output bus a packet heading in direction d competes for.
    function automatic logic [1:0] sel_for(input dir_e d, input logic [1:0] sl,
                                           input logic [1:0] sr, input logic [1:0] su);
        case (d)
            DIR_LEFT:  return sl;
            DIR_RIGHT: return sr;
            DIR_UP:    return su;
            default:   return 2'b00;
        endcase
    endfunction

    // A packet is deflected when it requested a direction but the arbiter
    // gave that output bus to some other input port.
    function automatic logic is_deflected(input dir_e d, input dir_e own,
                                          input logic [1:0] sl, input logic [1:0] sr,
                                          input logic [1:0] su);
        return (d != DIR_VOID) && (sel_for(d, sl, sr, su) != own);
    endfunction

    function automatic logic [1:0] count3(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

endpackage

`default_nettype wire

// File: rtl/t_route_stage_if.sv
// ============================================================================
// Module      : t_route_stage_if
// Description : Bus bundle between the port inputs / arbiter and the route
//               stage. slave = route stage view, master = environment view.
//   l/r/u_bus_i  : incoming packets (left child, right child, parent)
//   sel_l/r/u    : arbiter select lines for the three output buses
//   clr_cnt      : synchronous clear of the statistics counters
//   l/r/u_pkt_o  : registered packets
//   d_l/r/u      : registered direction requests
//   pkt_cnt      : saturating count of accepted valid packets
//   defl_cnt     : saturating count of deflected packets
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface t_route_stage_if #(
    parameter int P_W = 49,
    parameter int C_W = 16
);
    logic [P_W-1:0] l_bus_i;
    logic [P_W-1:0] r_bus_i;
    logic [P_W-1:0] u_bus_i;
    logic [1:0]     sel_l;
    logic [1:0]     sel_r;
    logic [1:0]     sel_u;
    logic           clr_cnt;
    logic [P_W-1:0] l_pkt_o;
    logic [P_W-1:0] r_pkt_o;
    logic [P_W-1:0] u_pkt_o;
    logic [1:0]     d_l;
    logic [1:0]     d_r;
    logic [1:0]     d_u;
    logic [C_W-1:0] pkt_cnt;
    logic [C_W-1:0] defl_cnt;

    modport master (
        output l_bus_i, r_bus_i, u_bus_i, sel_l, sel_r, sel_u, clr_cnt,
        input  l_pkt_o, r_pkt_o, u_pkt_o, d_l, d_r, d_u, pkt_cnt, defl_cnt
    );

    modport slave (
        input  l_bus_i, r_bus_i, u_bus_i, sel_l, sel_r, sel_u, clr_cnt,
        output l_pkt_o, r_pkt_o, u_pkt_o, d_l, d_r, d_u, pkt_cnt, defl_cnt
    );
endinterface

`default_nettype wire

// File: rtl/t_route_stage_dir_decode.sv
// ============================================================================
// Module      : t_dir_decode
// Description : Combinational single-port destination decode for a t-switch
//               at tree level LEVEL, position POSX.
//   i_valid : packet valid flag
//   i_addr  : destination leaf address
//   o_dir   : requested direction (VOID/LEFT/RIGHT/UP)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module t_dir_decode
    import t_route_stage_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int LEVEL = 1,
    parameter int POSX  = 0,
    parameter int TOP   = 0
) (
    input  wire logic           i_valid,
    input  wire logic [A_W-1:0] i_addr,
    output dir_e                o_dir
);

    logic w_side;     // 0 = left subtree, 1 = right subtree
    logic w_in_sub;   // destination lies below this switch

    // Address bits at or above A_W read as zero.
    generate
        if (LEVEL < A_W) begin : g_side
            assign w_side = i_addr[LEVEL];
        end else begin : g_side_zero
            assign w_side = 1'b0;
        end

        if (LEVEL + 1 < A_W) begin : g_sub
            assign w_in_sub = (32'(i_addr[A_W-1:LEVEL+1]) == 32'(POSX));
        end else begin : g_sub_zero
            assign w_in_sub = (POSX == 0);
        end
    endgenerate

    always_comb begin
        o_dir = DIR_VOID;
        if (i_valid) begin
            if ((TOP == 0) && !w_in_sub) begin
                o_dir = DIR_UP;
            end else if (w_side) begin
                o_dir = DIR_RIGHT;
            end else begin
                o_dir = DIR_LEFT;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/t_route_stage.sv
// ============================================================================
// Module      : t_route_stage
// Description : Per-port input pipeline stage of the BFT t-switch. Registers
//               the left/right/up packets with their decoded direction
//               requests (one cycle latency, no backpressure) and keeps
//               saturating packet / deflection counters from the arbiter's
//               select lines.
//   clk   : clock, rising edge
//   reset : synchronous, active low
//   bus   : t_route_stage_if.slave (packets in/out, selects, counters)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module t_route_stage
    import t_route_stage_pkg::*;
#(
    parameter int P_W   = 49,
    parameter int A_W   = 8,
    parameter int LEVEL = 1,
    parameter int POSX  = 0,
    parameter int TOP   = 0,
    parameter int C_W   = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    t_route_stage_if.slave bus
);

    localparam int VB = pkt_valid_bit(P_W);
    localparam int AM = pkt_addr_msb(P_W);

    logic [P_W-1:0] w_bus [3];
    dir_e           w_dir [3];
    logic [2:0]     w_defl;

    logic [P_W-1:0] r_pkt [3];
    dir_e           r_dir [3];
    logic [C_W-1:0] r_pkt_cnt;
    logic [C_W-1:0] r_defl_cnt;

    assign w_bus[0] = bus.l_bus_i;
    assign w_bus[1] = bus.r_bus_i;
    assign w_bus[2] = bus.u_bus_i;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_port
            t_dir_decode #(
                .A_W   (A_W),
                .LEVEL (LEVEL),
                .POSX  (POSX),
                .TOP   (TOP)
            ) u_dec (
                .i_valid (w_bus[gi][VB]),
                .i_addr  (w_bus[gi][AM -: A_W]),
                .o_dir   (w_dir[gi])
            );

            // Deflection is judged on the packet currently presented to
            // the arbiter, i.e. the registered one.
            assign w_defl[gi] = is_deflected(r_dir[gi], port_code(gi),
                                             bus.sel_l, bus.sel_r, bus.sel_u);
        end
    endgenerate

    logic [1:0]   w_nvalid;
    logic [1:0]   w_ndefl;
    logic [C_W:0] w_pkt_sum;
    logic [C_W:0] w_defl_sum;

    assign w_nvalid   = count3(w_bus[0][VB], w_bus[1][VB], w_bus[2][VB]);
    assign w_ndefl    = count3(w_defl[0], w_defl[1], w_defl[2]);
    // One extra bit catches overflow so the counters can pin at all-ones.
    assign w_pkt_sum  = {1'b0, r_pkt_cnt}  + (C_W+1)'(w_nvalid);
    assign w_defl_sum = {1'b0, r_defl_cnt} + (C_W+1)'(w_ndefl);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                r_pkt[i] <= '0;
                r_dir[i] <= DIR_VOID;
            end
            r_pkt_cnt  <= '0;
            r_defl_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_pkt[i] <= w_bus[i];
                r_dir[i] <= w_dir[i];
            end
            if (bus.clr_cnt) begin
                r_pkt_cnt  <= '0;
                r_defl_cnt <= '0;
            end else begin
                r_pkt_cnt  <= w_pkt_sum[C_W]  ? '1 : w_pkt_sum[C_W-1:0];
                r_defl_cnt <= w_defl_sum[C_W] ? '1 : w_defl_sum[C_W-1:0];
            end
        end
    end

    assign bus.l_pkt_o  = r_pkt[0];
    assign bus.r_pkt_o  = r_pkt[1];
    assign bus.u_pkt_o  = r_pkt[2];
    assign bus.d_l      = r_dir[0];
    assign bus.d_r      = r_dir[1];
    assign bus.d_u      = r_dir[2];
    assign bus.pkt_cnt  = r_pkt_cnt;
    assign bus.defl_cnt = r_defl_cnt;

endmodule

`default_nettype wire
